// File: rtl/fetch_controller_pkg.sv
// Shared fetch definitions: FSM state encodings, reset/bubble/halt constants
// and a saturating counter helper, imported by the RTL and the bench.
package fetch_controller_pkg;

    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_controller_if_id_reg.sv
// IF/ID pipeline register: instruction, its address and a valid flag.
// Flush (bubble insert) wins over hold; otherwise a new instruction loads.
module if_id_reg #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               hold,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ADDR_W-1:0]  pc_d,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic               valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_reg <= NOP_INSTR;
            pc_reg    <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            instr_reg <= NOP_INSTR;
            pc_reg    <= '0;
            valid_reg <= 1'b0;
        end else if (!hold) begin
            instr_reg <= instr_d;
            pc_reg    <= pc_d;
            valid_reg <= 1'b1;
        end
    end

    assign instr = instr_reg;
    assign pc    = pc_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, the IDLE/RUN/HALT FSM and the
// delivered-instruction counter, and feeds the IF/ID register.
module fetch_controller #(
    parameter int                 ADDR_W      = 16,
    parameter int                 INSTR_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC    = ADDR_W'(fetch_controller_pkg::RESET_PC),
    parameter logic [INSTR_W-1:0] NOP_INSTR   = INSTR_W'(fetch_controller_pkg::NOP_INSTR),
    parameter logic [3:0]         HALT_OPCODE = fetch_controller_pkg::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               resume,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    import fetch_controller_pkg::*;

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       count_reg, count_next;
    logic              halted_reg;
    logic              ifid_flush, ifid_hold;
    logic              halt_seen;

    assign halt_seen = (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            count_reg  <= 16'h0000;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            count_reg  <= count_next;
            // Decoded from the next state so halted is a clean register output.
            halted_reg <= (state_next == ST_HALT);
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_RUN;
                ifid_flush = 1'b1;
            end
            ST_RUN: begin
                if (branch_taken) begin
                    pc_next    = branch_target;
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    count_next = sat_inc16(count_reg);
                    // A HALT is delivered like any instruction but freezes the PC on itself.
                    if (halt_seen) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next = pc_reg + ADDR_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (branch_taken) begin
                    pc_next    = branch_target;
                    ifid_flush = 1'b1;
                    state_next = ST_RUN;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (resume) begin
                    pc_next    = pc_reg + ADDR_W'(1);
                    ifid_flush = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ifid_flush = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .flush  (ifid_flush),
        .hold   (ifid_hold),
        .instr_d(imem_instr),
        .pc_d   (pc_reg),
        .instr  (if_id_instr),
        .pc     (if_id_pc),
        .valid  (if_id_valid)
    );

    assign imem_addr   = pc_reg;
    assign halted      = halted_reg;
    assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, reset/saturation
// sequences, then random stimulus against a behavioural fetch model.
module tb_fetch_controller;

    import fetch_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        resume = 1'b0;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;
    assign imem_instr = mem[imem_addr];

    fetch_controller dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .resume       (resume),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    typedef struct {
        logic        s, b, r;
        logic [15:0] t;
        logic [15:0] e_addr, e_instr, e_pc;
        logic        e_valid, e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, b, input logic [15:0] t, input logic r,
                                input logic [15:0] ea, ei, ep, input logic ev, eh,
                                input logic [15:0] ec);
        vec_t v;
        v.s = s; v.b = b; v.t = t; v.r = r;
        v.e_addr = ea; v.e_instr = ei; v.e_pc = ep;
        v.e_valid = ev; v.e_halt = eh; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] ea, ei, ep,
                         input logic ev, eh, input logic [15:0] ec);
        n_checks++;
        if ({imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count} !==
            {ea, ei, ep, ev, eh, ec}) begin
            n_errors++;
            $display("FAIL %s: got addr=%h instr=%h pc=%h v=%b h=%b cnt=%h, want addr=%h instr=%h pc=%h v=%b h=%b cnt=%h",
                     name, imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count,
                     ea, ei, ep, ev, eh, ec);
        end else begin
            $display("ok   %s: addr=%h instr=%h pc=%h v=%b h=%b cnt=%h",
                     name, imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count);
        end
    endtask

    task automatic drive(input logic s, b, input logic [15:0] t, input logic r);
        stall = s; branch_taken = b; branch_target = t; resume = r;
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset(input string name);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check(name, RESET_PC, NOP_INSTR, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check({name, "_idle"}, RESET_PC, NOP_INSTR, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    // Behavioural model: what a fetch unit should show after one clock.
    logic        m_halted;
    logic [15:0] m_pc, m_instr, m_ipc, m_count;
    logic        m_valid;

    task automatic model_step(input logic s, b, input logic [15:0] t, input logic r);
        logic [15:0] word;
        word = mem[m_pc];
        if (b) begin
            m_pc = t; m_instr = NOP_INSTR; m_ipc = 0; m_valid = 0; m_halted = 0;
        end else if (s) begin
            // everything holds
        end else if (m_halted) begin
            m_instr = NOP_INSTR; m_ipc = 0; m_valid = 0;
            if (r) begin
                m_pc = m_pc + 16'd1;
                m_halted = 0;
            end
        end else begin
            m_instr = word; m_ipc = m_pc; m_valid = 1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (word[15:12] == HALT_OPCODE) m_halted = 1;
            else m_pc = m_pc + 16'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 7) != 0 && w[15:12] == 4'hF) w[15:12] = 4'hE;
            mem[i] = w;
        end
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[4] = 16'h5555; mem[5] = 16'hF000; mem[6] = 16'h6666; mem[7] = 16'h7777;
        mem[16'h0010] = 16'h1010; mem[16'h0040] = 16'h4040; mem[16'hFFFF] = 16'hABCD;

        //              s     b     target     r     addr       instr      pc         v     h     cnt
        vecs.push_back(mk(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'h1111, 16'h0000, 1'b1, 1'b0, 16'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 16'h2222, 16'h0001, 1'b1, 1'b0, 16'd2));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 16'h2222, 16'h0001, 1'b1, 1'b0, 16'd2));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 16'h2222, 16'h0001, 1'b1, 1'b0, 16'd2));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 16'h3333, 16'h0002, 1'b1, 1'b0, 16'd3));
        vecs.push_back(mk(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd3));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0041, 16'h4040, 16'h0040, 1'b1, 1'b0, 16'd4));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0004, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd4));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'h5555, 16'h0004, 1'b1, 1'b0, 16'd5));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'hF000, 16'h0005, 1'b1, 1'b1, 16'd6));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'd6));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'd6));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd6));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0007, 16'h6666, 16'h0006, 1'b1, 1'b0, 16'd7));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd7));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'hF000, 16'h0005, 1'b1, 1'b1, 16'd8));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'hF000, 16'h0005, 1'b1, 1'b1, 16'd8));
        vecs.push_back(mk(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd8));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0011, 16'h1010, 16'h0010, 1'b1, 1'b0, 16'd9));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd9));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hABCD, 16'hFFFF, 1'b1, 1'b0, 16'd10));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'h1111, 16'h0000, 1'b1, 1'b0, 16'd11));

        #8 rst = 1'b1;
        @(negedge clk);
        check("reset", RESET_PC, NOP_INSTR, 16'h0000, 1'b0, 1'b0, 16'h0000);

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].b, vecs[i].t, vecs[i].r);
            @(negedge clk);
            check($sformatf("row%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc,
                  vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_cnt);
        end

        // Counter saturation: preload just below the limit while stalled.
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        force dut.count_reg = 16'hFFFE;
        #1 release dut.count_reg;
        @(negedge clk);
        check("sat_hold", 16'h0001, 16'h1111, 16'h0000, 1'b1, 1'b0, 16'hFFFE);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check("sat_reach", 16'h0002, 16'h2222, 16'h0001, 1'b1, 1'b0, 16'hFFFF);
        @(negedge clk);
        check("sat_stay", 16'h0003, 16'h3333, 16'h0002, 1'b1, 1'b0, 16'hFFFF);

        // Reset mid-run with the PC parked at 7.
        drive(1'b0, 1'b1, 16'h0007, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check("park7", 16'h0007, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF);
        async_reset("reset_run");
        @(negedge clk);
        check("refetch0", 16'h0001, 16'h1111, 16'h0000, 1'b1, 1'b0, 16'd1);

        // Reset while halted.
        drive(1'b0, 1'b1, 16'h0005, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check("halt_again", 16'h0005, 16'hF000, 16'h0005, 1'b1, 1'b1, 16'd2);
        async_reset("reset_halt");

        // Random phase against the model, starting in RUN at pc 0.
        m_halted = 0; m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = 0; m_valid = 0; m_count = 0;
        for (int n = 0; n < 600; n++) begin
            logic        s, b, r;
            logic [15:0] t;
            s = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 2) == 0);
            t = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom_range(0, 63));
            drive(s, b, t, r);
            model_step(s, b, t, r);
            @(negedge clk);
            check($sformatf("rand%0d", n), m_pc, m_instr, m_ipc, m_valid, m_halted, m_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
